// File: rtl/seq_adder_n.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock, LSB digit first.
// Optional subtract mode is compiled in with SEQ_ADDER_SUB_EN (adds the sub port).
module seq_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SEQ_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    // state   | meaning
    // S_IDLE  | waiting for start, last result held on sum/cout
    // S_RUN   | one digit consumed per clock, K clocks total

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("seq_adder_n: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic [DIGIT:0]   w_dadd;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_b_in;
    logic             w_cin;

`ifdef SEQ_ADDER_SUB_EN
    // Subtraction as a + ~b + 1; the inversion is applied once at capture.
    assign w_b_in = sub ? ~b : b;
    assign w_cin  = sub;
`else
    assign w_b_in = b;
    assign w_cin  = 1'b0;
`endif

    assign w_dadd = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};

    // New digit enters at the top; after K shifts the LSB digit sits at bit 0.
    assign w_res_next = WIDTH'({w_dadd[DIGIT-1:0], r_res} >> DIGIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_cin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_dadd[DIGIT];
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_dadd[DIGIT];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_seq_adder_n.sv
// Directed bench for seq_adder_n: one DIGIT=1 and one DIGIT=4 instance, WIDTH=8.
// Subtract vectors run only when SEQ_ADDER_SUB_EN is defined.
module tb_seq_adder_n;

    logic       clk = 1'b0;
    logic       rst1_n, rst4_n;
    logic       start1, start4;
    logic [7:0] a1, b1, a4, b4;
    logic [7:0] sum1, sum4;
    logic       cout1, cout4, busy1, busy4, done1, done4;
`ifdef SEQ_ADDER_SUB_EN
    logic       sub1, sub4;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_adder_n #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .start(start1), .a(a1), .b(b1),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub1),
`endif
        .sum(sum1), .cout(cout1), .busy(busy1), .done(done1)
    );

    seq_adder_n #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .start(start4), .a(a4), .b(b4),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub4),
`endif
        .sum(sum4), .cout(cout4), .busy(busy4), .done(done4)
    );

    // Starts an operation on the selected instance; returns just after the accepting edge.
    task automatic start_op(input bit sel4, input logic [7:0] av, input logic [7:0] bv);
        if (sel4) begin start4 = 1'b1; a4 = av; b4 = bv; end
        else      begin start1 = 1'b1; a1 = av; b1 = bv; end
        @(posedge clk); #1;
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    // Edges from now until done is seen high; -1 if it never comes within the budget.
    task automatic wait_done(input bit sel4, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if ((sel4 ? done4 : done1) === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst1_n = 1'b0; rst4_n = 1'b0;
        start1 = 1'b0; start4 = 1'b0;
        a1 = 8'hAA; b1 = 8'h55; a4 = 8'hAA; b4 = 8'h55;
`ifdef SEQ_ADDER_SUB_EN
        sub1 = 1'b0; sub4 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({sum1, cout1, busy1, done1} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_dut1: got sum=%h cout=%b busy=%b done=%b, want all zero", sum1, cout1, busy1, done1);
        end
        n_tests++;
        if ({sum4, cout4, busy4, done4} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_dut4: got sum=%h cout=%b busy=%b done=%b, want all zero", sum4, cout4, busy4, done4);
        end
        rst1_n = 1'b1; rst4_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int cyc;
        start_op(1'b0, 8'h00, 8'h00);
        wait_done(1'b0, cyc);
        n_tests++;
        if (cyc !== 8) begin n_fail++; $display("FAIL zero_latency: got %0d, want 8", cyc); end
        n_tests++;
        if (sum1 !== 8'h00 || cout1 !== 1'b0) begin
            n_fail++; $display("FAIL zero_result: got sum=%h cout=%b, want 00/0", sum1, cout1);
        end
    endtask

    task automatic test_carry_out;
        int cyc = -1;
        int busy_cnt = 0;
        int hold_bad = 0;
        start_op(1'b0, 8'hFF, 8'h01);
        if (busy1 === 1'b1) busy_cnt++;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1) begin cyc = i; break; end
            if (busy1 === 1'b1) busy_cnt++;
            if (sum1 !== 8'h00 || cout1 !== 1'b0) hold_bad++;
        end
        n_tests++;
        if (cyc !== 8) begin n_fail++; $display("FAIL carry_latency: got %0d, want 8", cyc); end
        n_tests++;
        if (busy_cnt !== 8) begin n_fail++; $display("FAIL carry_busy_cycles: got %0d, want 8", busy_cnt); end
        n_tests++;
        if (hold_bad !== 0) begin n_fail++; $display("FAIL carry_sum_hold: %0d cycles showed a changed sum, want 0", hold_bad); end
        n_tests++;
        if (sum1 !== 8'h00 || cout1 !== 1'b1) begin
            n_fail++; $display("FAIL carry_result: got sum=%h cout=%b, want 00/1", sum1, cout1);
        end
        @(posedge clk); #1;
        n_tests++;
        if (done1 !== 1'b0) begin n_fail++; $display("FAIL carry_done_pulse: done=%b one cycle later, want 0", done1); end
    endtask

    task automatic test_ignore_busy_start;
        int ndone = 0;
        start_op(1'b0, 8'h35, 8'h4A);
        repeat (2) @(posedge clk);
        #1;
        start_op(1'b0, 8'h11, 8'h11);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1) ndone++;
        end
        n_tests++;
        if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d, want 1", ndone); end
        n_tests++;
        if (sum1 !== 8'h7F || cout1 !== 1'b0) begin
            n_fail++; $display("FAIL ignore_result: got sum=%h cout=%b, want 7F/0", sum1, cout1);
        end
    endtask

    task automatic test_reset_abort;
        int cyc;
        int ndone = 0;
        start_op(1'b0, 8'hF0, 8'h0F);
        repeat (3) @(posedge clk);
        #1;
        rst1_n = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({sum1, cout1, busy1, done1} !== 11'h0) begin
            n_fail++;
            $display("FAIL abort_state: got sum=%h cout=%b busy=%b done=%b, want all zero", sum1, cout1, busy1, done1);
        end
        rst1_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1 || busy1 === 1'b1) ndone++;
        end
        n_tests++;
        if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: %0d active cycles after abort, want 0", ndone); end
        start_op(1'b0, 8'h0F, 8'h01);
        wait_done(1'b0, cyc);
        n_tests++;
        if (cyc !== 8) begin n_fail++; $display("FAIL abort_restart_latency: got %0d, want 8", cyc); end
        n_tests++;
        if (sum1 !== 8'h10 || cout1 !== 1'b0) begin
            n_fail++; $display("FAIL abort_restart_result: got sum=%h cout=%b, want 10/0", sum1, cout1);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        start_op(1'b1, 8'h9C, 8'h78);
        wait_done(1'b1, cyc);
        n_tests++;
        if (cyc !== 2) begin n_fail++; $display("FAIL b2b_first_latency: got %0d, want 2", cyc); end
        n_tests++;
        if (sum4 !== 8'h14 || cout4 !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first_result: got sum=%h cout=%b, want 14/1", sum4, cout4);
        end
        start_op(1'b1, 8'h01, 8'h02);
        n_tests++;
        if (busy4 !== 1'b1 || done4 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b, want 1/0", busy4, done4);
        end
        wait_done(1'b1, cyc);
        n_tests++;
        if (cyc !== 2) begin n_fail++; $display("FAIL b2b_second_latency: got %0d, want 2", cyc); end
        n_tests++;
        if (sum4 !== 8'h03 || cout4 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second_result: got sum=%h cout=%b, want 03/0", sum4, cout4);
        end
    endtask

`ifdef SEQ_ADDER_SUB_EN
    task automatic test_subtract;
        logic [7:0] va [3] = '{8'h05, 8'h07, 8'h80};
        logic [7:0] vb [3] = '{8'h07, 8'h05, 8'h80};
        logic [7:0] vs [3] = '{8'hFE, 8'h02, 8'h00};
        logic       vc [3] = '{1'b0, 1'b1, 1'b1};
        int cyc;
        sub1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_op(1'b0, va[i], vb[i]);
            wait_done(1'b0, cyc);
            n_tests++;
            if (cyc !== 8 || sum1 !== vs[i] || cout1 !== vc[i]) begin
                n_fail++;
                $display("FAIL sub_%0d: got lat=%0d sum=%h cout=%b, want 8/%h/%b", i, cyc, sum1, cout1, vs[i], vc[i]);
            end
        end
        sub1 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_carry_out();
        test_ignore_busy_start();
        test_reset_abort();
        test_back_to_back();
`ifdef SEQ_ADDER_SUB_EN
        test_subtract();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
